sd_spi_card_responder: RTL and testbench
========================================

// Module: sd_spi_card_responder
// PURPOSE
//  Card-side SPI-mode responder: the device end of the SD host link driven by sd_top.
//  Deserialises 48-bit host commands from sd_mosi, checks CRC7, tracks card init state, and
//  serialises R1/R3/R7 responses on sd_miso. Serves as an on-FPGA card model for loopback and
//  bring-up of the host controller. sd_clk/sd_cs_n arrive asynchronously and are oversampled on sclk.
// PARAMETERS
//  NCR_BYTES       1   0xFF filler bytes sent between command end and response start (1..8)
//  ACMD41_RETRIES  2   ACMD41 count answered with idle (0x01) before returning ready (0x00)
//  OCR_VALUE       32'hC0FF_8000  OCR returned in the CMD58 R3 payload
// PORTS
//  sclk         in   1   system clock; must be >= 4x sd_clk frequency
//  rst          in   1   synchronous active-high reset
//  sd_clk       in   1   SPI clock from host, mode 0, async to sclk
//  sd_cs_n      in   1   chip select from host, active low, async
//  sd_mosi      in   1   command data from host, async
//  sd_miso      out  1   response data to host
//  cmd_valid    out  1   1-sclk pulse when a full command frame has been decoded
//  cmd_index    out  6   index of last decoded command
//  cmd_arg      out  32  argument of last decoded command
//  cmd_crc_err  out  1   CRC7 mismatch on last decoded command (checked commands only)
//  card_ready   out  1   high once ACMD41 returned 0x00; cleared by CMD0
// BEHAVIOUR
//  Reset: sd_miso=1, cmd_valid=0, cmd_index=0, cmd_arg=0, cmd_crc_err=0, card_ready=0, state=IDLE,
//   acmd_pending=0, retry count=0.
//  Sync: sd_clk, sd_cs_n, sd_mosi each pass 2 FFs; rise/fall = compare sync vs previous sync sample.
//  Sample sd_mosi on detected sd_clk rise; update sd_miso on detected fall (mode 0).
//  FSM:
//   IDLE    : sd_miso=1. cs_n low -> HUNT.
//   HUNT    : on each rise, wait for bit 0 (start bit) -> RX_CMD with bit count=1.
//   RX_CMD  : shift 48 bits MSB-first; bit1 must be 1 (else back to HUNT, no response).
//             At bit 48 -> DECODE.
//   DECODE  : one sclk; latch cmd_index/arg/crc_err, pulse cmd_valid; build response -> NCR.
//   NCR     : drive 1 for NCR_BYTES*8 falls -> TX_RESP.
//   TX_RESP : shift response MSB-first, one bit per fall; after last bit's following fall
//             drive 1 -> HUNT.
//  cs_n high in any state: abort within 3 sclk of sync edge -> IDLE, sd_miso=1, no cmd_valid,
//   partial frame discarded; acmd_pending unchanged.
//  CRC7: poly x^7+x^3+1, init 0, over first 40 bits; compared with bits[7:1]. Checked only for
//   CMD0 and CMD8; other commands crc_err=0.
//  R1 bits: [0]=idle (!card_ready), [2]=illegal cmd, [3]=CRC error, others 0.
//  Responses (idle bit per state after command effect):
//   CRC error       : R1 only, 0x08|idle; no state change.
//   CMD0            : card_ready=0, retry cnt=0 -> R1 0x01.
//   CMD8            : R7 40 bits: R1, 0x00, 0x00, arg[11:8], arg[7:0] echoed.
//   CMD55           : acmd_pending=1 -> R1.
//   CMD41 w/ pending: if retry cnt<ACMD41_RETRIES: cnt++ -> 0x01; else card_ready=1 -> 0x00.
//   CMD58           : R3 40 bits: R1 then OCR_VALUE; bit31 forced to card_ready.
//   any other       : R1 with illegal bit (0x04|idle).
//  acmd_pending cleared by any decoded command other than CMD55 (incl. CMD41 and errors).
//  Host clocking beyond response: ones; new start bit only recognised in HUNT (ignored in NCR/TX).
//  Response max 40 bits: 40-bit shift reg + 6-bit counter; NCR counter 6 bits.
// STRUCTURE
//  sd_pkg: CMD index localparams (CMD0/8/41/55/58), R1 bit positions, response lengths (8/40),
//   FSM state enum.
//  Sub-module sd_crc7: serial CRC7 with clear/enable/bit inputs, 7-bit output.
//  Top holds synchronisers, edge detect, FSM, shift registers, init-state tracking.
// TESTING  (sclk 50 MHz, sd_clk 400 kHz and 12.5 MHz, NCR_BYTES=1)
//  CMD0 40 00 00 00 00 95 -> one 0xFF byte then 0x01; cmd_valid pulse, index 0, crc_err 0.
//  CMD8 48 00 00 01 AA 87 -> 0xFF, then 01 00 00 01 AA.
//  CMD0 with CRC byte 0x94 -> R1 0x09, cmd_crc_err=1, card_ready unchanged.
//  CMD55+CMD41 x3 (RETRIES=2) -> 0x01,0x01,0x01,0x01,0x01,0x00; card_ready=1; CMD58 -> 00 C0 FF 80 00.
//  cs_n high after 20 command bits, then full CMD0 -> first frame no cmd_valid/response; second 0x01.
//  CMD17 51 00 00 00 00 FF when idle -> R1 0x05; CMD41 without CMD55 -> 0x05; rst mid-TX -> sd_miso=1.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants, state encoding and R1 helper for the SPI-mode SD card responder.
package sd_pkg;

   // Command indices the card acts on
   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD8  = 6'd8;
   localparam logic [5:0] CMD41 = 6'd41;
   localparam logic [5:0] CMD55 = 6'd55;
   localparam logic [5:0] CMD58 = 6'd58;

   // R1 status bit positions
   localparam int unsigned R1_IDLE_BIT    = 0;
   localparam int unsigned R1_ILLEGAL_BIT = 2;
   localparam int unsigned R1_CRC_BIT     = 3;

   // Response lengths in bits
   localparam logic [5:0] RESP_LEN_R1   = 6'd8;
   localparam logic [5:0] RESP_LEN_LONG = 6'd40;

   // Command frame geometry
   localparam logic [5:0] FRAME_LAST_BIT = 6'd47;
   localparam logic [5:0] CRC_SPAN_BITS  = 6'd40;

   typedef enum logic [2:0] {
      StIdle,
      StHunt,
      StRxCmd,
      StDecode,
      StNcr,
      StTxResp
   } sd_state_e;

   function automatic logic [7:0] r1_byte(input logic idle, input logic illegal,
                                          input logic crc_err);
      logic [7:0] r;
      r                 = '0;
      r[R1_IDLE_BIT]    = idle;
      r[R1_ILLEGAL_BIT] = illegal;
      r[R1_CRC_BIT]     = crc_err;
      return r;
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
module sd_crc7 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] crc_q;
   logic       fb;

   assign fb = crc_q[6] ^ bit_in;

   // Galois-form shift: feedback taps at x^3 and x^0
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         crc_q <= '0;
      end else if (en) begin
         crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card-side SPI-mode SD responder: receives 48-bit commands, checks CRC7, tracks the
// init sequence and returns R1/R3/R7 responses. Host signals are oversampled on sclk.
module sd_spi_card_responder
   import sd_pkg::*;
#(
   parameter int unsigned NCR_BYTES      = 1,
   parameter int unsigned ACMD41_RETRIES = 2,
   parameter logic [31:0] OCR_VALUE      = 32'hC0FF_8000
) (
   input  logic        sclk,
   input  logic        rst,
   input  logic        sd_clk,
   input  logic        sd_cs_n,
   input  logic        sd_mosi,
   output logic        sd_miso,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        cmd_crc_err,
   output logic        card_ready
);

   localparam logic [5:0] NCR_LAST = 6'(NCR_BYTES * 8 - 1);

   // Synchronisers
   logic clk_meta, clk_sync, clk_prev;
   logic cs_meta, cs_sync;
   logic mosi_meta, mosi_sync;
   logic clk_rise, clk_fall;

   // State
   sd_state_e   state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [47:0] frame_q, frame_d;
   logic [5:0]  ncr_cnt_q, ncr_cnt_d;
   logic [5:0]  tx_cnt_q, tx_cnt_d;
   logic [39:0] resp_q, resp_d;
   logic [5:0]  resp_len_q, resp_len_d;
   logic        miso_q, miso_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [5:0]  cmd_index_q, cmd_index_d;
   logic [31:0] cmd_arg_q, cmd_arg_d;
   logic        cmd_crc_err_q, cmd_crc_err_d;
   logic        card_ready_q, card_ready_d;
   logic        acmd_pending_q, acmd_pending_d;
   logic [7:0]  retry_cnt_q, retry_cnt_d;

   // CRC and decode helpers
   logic        crc_clr, crc_en;
   logic [6:0]  crc_val;
   logic [5:0]  dec_index;
   logic [31:0] dec_arg;
   logic        dec_checked, dec_crc_err, retry_below, illegal;
   logic        unused_frame;

   // Two-stage synchronisers plus a previous sample of sd_clk for edge detection
   always_ff @(posedge sclk) begin
      if (rst) begin
         clk_meta  <= 1'b0;
         clk_sync  <= 1'b0;
         clk_prev  <= 1'b0;
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         mosi_meta <= 1'b1;
         mosi_sync <= 1'b1;
      end else begin
         clk_meta  <= sd_clk;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         cs_meta   <= sd_cs_n;
         cs_sync   <= cs_meta;
         mosi_meta <= sd_mosi;
         mosi_sync <= mosi_meta;
      end
   end

   assign clk_rise = clk_sync & ~clk_prev;
   assign clk_fall = ~clk_sync & clk_prev;

   sd_crc7 u_crc7 (
      .clk    (sclk),
      .rst    (rst),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (mosi_sync),
      .crc    (crc_val)
   );

   assign dec_index   = frame_q[45:40];
   assign dec_arg     = frame_q[39:8];
   assign dec_checked = (dec_index == CMD0) || (dec_index == CMD8);
   // The whole trailing byte must read {crc7, 1}; a cleared end bit counts as a bad checksum
   assign dec_crc_err = dec_checked && (frame_q[7:0] != {crc_val, 1'b1});
   assign retry_below = {24'b0, retry_cnt_q} < ACMD41_RETRIES;
   // Start and transmission bits are consumed by the receive FSM, not the decoder
   assign unused_frame = ^frame_q[47:46];

   // State register for the FSM, shifters and init-state tracking
   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q        <= StIdle;
         bit_cnt_q      <= '0;
         frame_q        <= '0;
         ncr_cnt_q      <= '0;
         tx_cnt_q       <= '0;
         resp_q         <= '0;
         resp_len_q     <= RESP_LEN_R1;
         miso_q         <= 1'b1;
         cmd_valid_q    <= 1'b0;
         cmd_index_q    <= '0;
         cmd_arg_q      <= '0;
         cmd_crc_err_q  <= 1'b0;
         card_ready_q   <= 1'b0;
         acmd_pending_q <= 1'b0;
         retry_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         frame_q        <= frame_d;
         ncr_cnt_q      <= ncr_cnt_d;
         tx_cnt_q       <= tx_cnt_d;
         resp_q         <= resp_d;
         resp_len_q     <= resp_len_d;
         miso_q         <= miso_d;
         cmd_valid_q    <= cmd_valid_d;
         cmd_index_q    <= cmd_index_d;
         cmd_arg_q      <= cmd_arg_d;
         cmd_crc_err_q  <= cmd_crc_err_d;
         card_ready_q   <= card_ready_d;
         acmd_pending_q <= acmd_pending_d;
         retry_cnt_q    <= retry_cnt_d;
      end
   end

   // Next-state: receive, decode, Ncr filler and response shift-out
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      frame_d        = frame_q;
      ncr_cnt_d      = ncr_cnt_q;
      tx_cnt_d       = tx_cnt_q;
      resp_d         = resp_q;
      resp_len_d     = resp_len_q;
      miso_d         = miso_q;
      cmd_valid_d    = 1'b0;
      cmd_index_d    = cmd_index_q;
      cmd_arg_d      = cmd_arg_q;
      cmd_crc_err_d  = cmd_crc_err_q;
      card_ready_d   = card_ready_q;
      acmd_pending_d = acmd_pending_q;
      retry_cnt_d    = retry_cnt_q;
      crc_clr        = 1'b0;
      crc_en         = 1'b0;
      illegal        = 1'b0;

      if (cs_sync) begin
         // Deselect aborts anything in flight; card init state is kept
         state_d = StIdle;
         miso_d  = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               miso_d  = 1'b1;
               state_d = StHunt;
            end
            StHunt: begin
               crc_clr = 1'b1;
               if (clk_rise && !mosi_sync) begin
                  frame_d   = '0;
                  bit_cnt_d = 6'd1;
                  state_d   = StRxCmd;
               end
            end
            StRxCmd: begin
               if (clk_rise) begin
                  frame_d   = {frame_q[46:0], mosi_sync};
                  crc_en    = bit_cnt_q < CRC_SPAN_BITS;
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd1 && !mosi_sync) begin
                     state_d = StHunt;
                  end else if (bit_cnt_q == FRAME_LAST_BIT) begin
                     state_d = StDecode;
                  end
               end
            end
            StDecode: begin
               cmd_valid_d    = 1'b1;
               cmd_index_d    = dec_index;
               cmd_arg_d      = dec_arg;
               cmd_crc_err_d  = dec_crc_err;
               acmd_pending_d = 1'b0;
               resp_len_d     = RESP_LEN_R1;
               resp_d         = '0;
               if (!dec_crc_err) begin
                  case (dec_index)
                     CMD0: begin
                        card_ready_d = 1'b0;
                        retry_cnt_d  = '0;
                     end
                     CMD8: begin
                        resp_len_d   = RESP_LEN_LONG;
                        resp_d[11:0] = dec_arg[11:0];
                     end
                     CMD55: acmd_pending_d = 1'b1;
                     CMD41: begin
                        if (!acmd_pending_q) begin
                           illegal = 1'b1;
                        end else if (retry_below) begin
                           retry_cnt_d = retry_cnt_q + 8'd1;
                        end else begin
                           card_ready_d = 1'b1;
                        end
                     end
                     CMD58: begin
                        resp_len_d    = RESP_LEN_LONG;
                        resp_d[31:0]  = {card_ready_d, OCR_VALUE[30:0]};
                     end
                     default: illegal = 1'b1;
                  endcase
               end
               // Idle bit reflects the state after this command took effect
               resp_d[39:32] = r1_byte(!card_ready_d, illegal, dec_crc_err);
               ncr_cnt_d     = '0;
               state_d       = StNcr;
            end
            StNcr: begin
               if (clk_fall) begin
                  miso_d    = 1'b1;
                  ncr_cnt_d = ncr_cnt_q + 6'd1;
                  if (ncr_cnt_q == NCR_LAST) begin
                     tx_cnt_d = '0;
                     state_d  = StTxResp;
                  end
               end
            end
            StTxResp: begin
               if (clk_fall) begin
                  if (tx_cnt_q == resp_len_q) begin
                     miso_d  = 1'b1;
                     state_d = StHunt;
                  end else begin
                     miso_d   = resp_q[39];
                     resp_d   = {resp_q[38:0], 1'b0};
                     tx_cnt_d = tx_cnt_q + 6'd1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign sd_miso     = miso_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_index   = cmd_index_q;
   assign cmd_arg     = cmd_arg_q;
   assign cmd_crc_err = cmd_crc_err_q;
   assign card_ready  = card_ready_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Self-checking bench: a bit-banged SPI host drives command frames, and a card model
// written from the SD command rules predicts every response byte and status output.
module tb_sd_spi_card_responder;

   localparam int unsigned RETRIES = 2;
   localparam logic [31:0] OCR     = 32'hC0FF_8000;

   logic        sclk = 1'b0;
   logic        rst = 1'b1;
   logic        sd_clk = 1'b0;
   logic        sd_cs_n = 1'b1;
   logic        sd_mosi = 1'b1;
   logic        sd_miso;
   logic        cmd_valid;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_crc_err;
   logic        card_ready;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int half_t = 40;

   // Card model state
   logic m_ready = 1'b0;
   logic m_pending = 1'b0;
   int   m_tries = 0;

   sd_spi_card_responder #(
      .NCR_BYTES      (1),
      .ACMD41_RETRIES (RETRIES),
      .OCR_VALUE      (OCR)
   ) dut (
      .sclk        (sclk),
      .rst         (rst),
      .sd_clk      (sd_clk),
      .sd_cs_n     (sd_cs_n),
      .sd_mosi     (sd_mosi),
      .sd_miso     (sd_miso),
      .cmd_valid   (cmd_valid),
      .cmd_index   (cmd_index),
      .cmd_arg     (cmd_arg),
      .cmd_crc_err (cmd_crc_err),
      .card_ready  (card_ready)
   );

   always #10 sclk = ~sclk;

   // Counts sclk cycles with cmd_valid high, so a stuck or stretched pulse shows up
   always @(negedge sclk) if (cmd_valid) valid_cnt <= valid_cnt + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
   function automatic logic [6:0] crc7_div(input logic [39:0] m);
      logic [46:0] d;
      d = {m, 7'b0};
      for (int i = 46; i >= 7; i--) begin
         if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
      end
      return d[6:0];
   endfunction

   function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, crc7_div({2'b01, idx, arg}), 1'b1};
   endfunction

   // Predicts the 7 bytes read after a frame: Ncr filler, response, then ones
   task automatic model_cmd(input logic [47:0] f, output logic [55:0] exp_rx,
                            output logic exp_err);
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [31:0] ocr;
      logic        illegal;
      logic [7:0]  pay[$];
      logic [7:0]  bytes[$];
      idx     = f[45:40];
      arg     = f[39:8];
      illegal = 1'b0;
      exp_err = (idx == 6'd0 || idx == 6'd8) && (f[7:0] != {crc7_div(f[47:8]), 1'b1});
      if (!exp_err) begin
         if (idx == 6'd0) begin
            m_ready = 1'b0;
            m_tries = 0;
         end else if (idx == 6'd8) begin
            pay.push_back(8'h00);
            pay.push_back(8'h00);
            pay.push_back({4'h0, arg[11:8]});
            pay.push_back(arg[7:0]);
         end else if (idx == 6'd55) begin
         end else if (idx == 6'd41 && m_pending) begin
            if (m_tries < RETRIES) m_tries++;
            else m_ready = 1'b1;
         end else if (idx == 6'd58) begin
            ocr     = OCR;
            ocr[31] = m_ready;
            for (int k = 3; k >= 0; k--) pay.push_back(ocr[k*8 +: 8]);
         end else begin
            illegal = 1'b1;
         end
      end
      m_pending = !exp_err && idx == 6'd55;
      bytes.push_back(8'hFF);
      bytes.push_back({4'b0, exp_err, illegal, 1'b0, !m_ready});
      foreach (pay[k]) bytes.push_back(pay[k]);
      while (bytes.size() < 7) bytes.push_back(8'hFF);
      exp_rx = '0;
      for (int k = 0; k < 7; k++) exp_rx = {exp_rx[47:0], bytes[k]};
   endtask

   // Puts host edges a few time units away from sclk edges
   task automatic host_align();
      @(negedge sclk);
      #3;
   endtask

   // One mode-0 bit. miso trails the host fall by up to three sclk, so it is read at the
   // end of the high phase rather than at the rising edge.
   task automatic xfer_bit(input logic b, output logic r);
      sd_mosi = b;
      #(half_t);
      sd_clk = 1'b1;
      #(half_t - 1);
      r = sd_miso;
      #1;
      sd_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [47:0] f, input int n);
      logic r;
      host_align();
      for (int i = 47; i > 47 - n; i--) xfer_bit(f[i], r);
   endtask

   task automatic read_bits(input int n, output logic [55:0] rx);
      logic r;
      rx = '0;
      for (int i = 0; i < n; i++) begin
         xfer_bit(1'b1, r);
         rx = {rx[54:0], r};
      end
      sd_mosi = 1'b1;
   endtask

   task automatic do_cmd(input string tag, input logic [47:0] f);
      logic [55:0] exp_rx;
      logic [55:0] rx;
      logic        exp_err;
      int          v0;
      v0 = valid_cnt;
      model_cmd(f, exp_rx, exp_err);
      send_bits(f, 48);
      read_bits(56, rx);
      check_eq({tag, ".resp"}, rx, exp_rx);
      check_eq({tag, ".valid"}, 64'(valid_cnt - v0), 64'd1);
      check_eq({tag, ".index"}, cmd_index, f[45:40]);
      check_eq({tag, ".arg"}, cmd_arg, f[39:8]);
      check_eq({tag, ".crc_err"}, cmd_crc_err, exp_err);
      check_eq({tag, ".ready"}, card_ready, m_ready);
   endtask

   initial begin
      logic [47:0] f;
      logic [55:0] rx;
      logic [5:0]  idx;
      logic [7:0]  mask;
      int          v0;
      int          pick;

      // Reset values
      repeat (4) @(negedge sclk);
      check_eq("rst.miso", sd_miso, 1'b1);
      check_eq("rst.valid", cmd_valid, 1'b0);
      check_eq("rst.index", cmd_index, 6'd0);
      check_eq("rst.arg", cmd_arg, 32'd0);
      check_eq("rst.crc_err", cmd_crc_err, 1'b0);
      check_eq("rst.ready", card_ready, 1'b0);
      rst = 1'b0;
      host_align();
      sd_cs_n = 1'b0;
      repeat (10) @(negedge sclk);

      // Slow bring-up clock for the first CMD0
      half_t = 1250;
      do_cmd("cmd0_slow", 48'h40_0000_0000_95);
      half_t = 40;
      do_cmd("cmd8", 48'h48_0000_01AA_87);
      do_cmd("cmd0_badcrc", 48'h40_0000_0000_94);
      for (int i = 0; i < 3; i++) begin
         do_cmd("cmd55", mk_frame(6'd55, 32'd0));
         do_cmd("acmd41", mk_frame(6'd41, 32'h4000_0000));
      end
      do_cmd("cmd58", mk_frame(6'd58, 32'd0));

      // Deselect after 20 bits: no decode, no response, then a clean CMD0
      v0 = valid_cnt;
      send_bits(48'h40_0000_0000_95, 20);
      sd_mosi = 1'b1;
      sd_cs_n = 1'b1;
      repeat (10) @(negedge sclk);
      check_eq("abort.miso", sd_miso, 1'b1);
      check_eq("abort.valid", 64'(valid_cnt - v0), 64'd0);
      check_eq("abort.ready", card_ready, 1'b1);
      host_align();
      sd_cs_n = 1'b0;
      repeat (10) @(negedge sclk);
      do_cmd("cmd0_after_abort", 48'h40_0000_0000_95);

      do_cmd("cmd17", 48'h51_0000_0000_FF);
      do_cmd("cmd41_nopend", mk_frame(6'd41, 32'd0));

      // Randomised command mix biased towards the init sequence
      for (int n = 0; n < 30; n++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0:       idx = 6'd0;
            1:       idx = 6'd8;
            2, 3, 4: idx = 6'd55;
            5, 6:    idx = 6'd41;
            7:       idx = 6'd58;
            default: idx = 6'($urandom_range(0, 63));
         endcase
         f = mk_frame(idx, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            mask = 8'($urandom_range(1, 255));
            f[7:0] = f[7:0] ^ mask;
         end
         do_cmd($sformatf("rnd%0d_cmd%0d", n, idx), f);
      end

      // Reset in the middle of a long response
      send_bits(mk_frame(6'd58, 32'd0), 48);
      read_bits(12, rx);
      @(negedge sclk);
      rst = 1'b1;
      repeat (2) @(negedge sclk);
      check_eq("rst_tx.miso", sd_miso, 1'b1);
      check_eq("rst_tx.ready", card_ready, 1'b0);
      check_eq("rst_tx.index", cmd_index, 6'd0);
      check_eq("rst_tx.arg", cmd_arg, 32'd0);
      rst = 1'b0;
      m_ready   = 1'b0;
      m_pending = 1'b0;
      m_tries   = 0;
      repeat (10) @(negedge sclk);
      check_eq("rst_tx.miso_after", sd_miso, 1'b1);
      for (int i = 0; i < 3; i++) begin
         do_cmd("post_rst_cmd55", mk_frame(6'd55, 32'd0));
         do_cmd("post_rst_acmd41", mk_frame(6'd41, 32'h4000_0000));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
